// File: rtl/voice_allocator.sv
// Note-event voice allocator: chooses a voice (match, free or oldest), then emits
// phase-step writes for every operator and a NoteOn mask update over a valid/ready port.
module voice_allocator #(
    parameter int NUM_VOICES    = 32,
    parameter int NUM_OPERATORS = 8,
    parameter int KEY_WIDTH     = 7
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_EventValid,
    output logic                  o_EventReady,
    input  logic                  i_EventNoteOn,
    input  logic [KEY_WIDTH-1:0]  i_EventKey,
    input  logic [15:0]           i_EventPhaseStep,
    output logic                  o_WriteValid,
    input  logic                  i_WriteReady,
    output logic [15:0]           o_WriteNumber,
    output logic [15:0]           o_WriteValue,
    output logic [NUM_VOICES-1:0] o_ActiveMask,
    output logic                  o_Busy
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int OW = $clog2(NUM_OPERATORS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_CLEAR, S_PHASE, S_SET, S_OFF
    } state_t;

    state_t state, state_next;

    logic                  ev_on;
    logic [KEY_WIDTH-1:0]  ev_key;
    logic [15:0]           ev_step;
    logic [VW-1:0]         target;
    logic [OW-1:0]         op_cnt;
    logic [NUM_VOICES-1:0] mask;
    logic [KEY_WIDTH-1:0]  keys [NUM_VOICES];
    logic [VW-1:0]         ages [NUM_VOICES];

    logic          match_found, free_found;
    logic [VW-1:0] match_idx, free_idx, steal_idx;
    logic [15:0]   mask_half, bit_sel;
    logic          event_accept, write_accept;

    assign event_accept = i_EventValid && o_EventReady;
    assign write_accept = o_WriteValid && i_WriteReady;

    // Lowest-index match and free voice; the steal candidate is the unique oldest voice.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        steal_idx   = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (!match_found && mask[v] && keys[v] == ev_key) begin
                match_found = 1'b1;
                match_idx   = VW'(v);
            end
            if (!free_found && !mask[v]) begin
                free_found = 1'b1;
                free_idx   = VW'(v);
            end
            if (ages[v] == VW'(NUM_VOICES - 1))
                steal_idx = VW'(v);
        end
    end

    always_comb begin
        mask_half = target[VW-1] ? mask[31:16] : mask[15:0];
        bit_sel   = 16'(1) << target[3:0];
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (event_accept) state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (ev_on) state_next = (match_found || !free_found) ? S_CLEAR : S_PHASE;
                else       state_next = match_found ? S_OFF : S_IDLE;
            end
            S_CLEAR:  if (write_accept) state_next = S_PHASE;
            S_PHASE:  if (write_accept && op_cnt == OW'(NUM_OPERATORS - 1)) state_next = S_SET;
            S_SET:    if (write_accept) state_next = S_IDLE;
            S_OFF:    if (write_accept) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_EventReady  = (state == S_IDLE);
        o_Busy        = (state != S_IDLE);
        o_WriteValid  = 1'b0;
        o_WriteNumber = '0;
        o_WriteValue  = '0;
        case (state)
            S_CLEAR, S_OFF: begin
                o_WriteValid  = 1'b1;
                o_WriteNumber = {2'b10, 5'b01000, target[VW-1], 8'h00};
                o_WriteValue  = mask_half & ~bit_sel;
            end
            S_PHASE: begin
                o_WriteValid  = 1'b1;
                o_WriteNumber = {2'b10, 6'h00, target, op_cnt};
                o_WriteValue  = ev_step;
            end
            S_SET: begin
                o_WriteValid  = 1'b1;
                o_WriteNumber = {2'b10, 5'b01000, target[VW-1], 8'h00};
                o_WriteValue  = mask_half | bit_sel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            ev_on   <= 1'b0;
            ev_key  <= '0;
            ev_step <= '0;
            target  <= '0;
            op_cnt  <= '0;
            mask    <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                keys[v] <= '0;
                ages[v] <= VW'(v);
            end
        end else begin
            case (state)
                S_IDLE: if (event_accept) begin
                    ev_on   <= i_EventNoteOn;
                    ev_key  <= i_EventKey;
                    ev_step <= i_EventPhaseStep;
                end
                S_LOOKUP: begin
                    op_cnt <= '0;
                    if (match_found)     target <= match_idx;
                    else if (free_found) target <= free_idx;
                    else                 target <= steal_idx;
                end
                S_CLEAR, S_OFF: if (write_accept) mask[target] <= 1'b0;
                S_PHASE: if (write_accept) op_cnt <= op_cnt + 1'b1;
                S_SET: if (write_accept) begin
                    mask[target] <= 1'b1;
                    keys[target] <= ev_key;
                    // Younger voices age by one; the later assignment makes the target youngest.
                    for (int unsigned v = 0; v < NUM_VOICES; v++)
                        if (ages[v] < ages[target]) ages[v] <= ages[v] + 1'b1;
                    ages[target] <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_ActiveMask = mask;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus randomized note traffic checked
// against an array-based allocation model.
module tb_voice_allocator;
    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic        i_EventValid;
    logic        o_EventReady;
    logic        i_EventNoteOn;
    logic [6:0]  i_EventKey;
    logic [15:0] i_EventPhaseStep;
    logic        o_WriteValid;
    logic        i_WriteReady;
    logic [15:0] o_WriteNumber;
    logic [15:0] o_WriteValue;
    logic [31:0] o_ActiveMask;
    logic        o_Busy;

    voice_allocator #(.NUM_VOICES(32), .NUM_OPERATORS(8), .KEY_WIDTH(7)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_EventValid(i_EventValid), .o_EventReady(o_EventReady),
        .i_EventNoteOn(i_EventNoteOn), .i_EventKey(i_EventKey),
        .i_EventPhaseStep(i_EventPhaseStep),
        .o_WriteValid(o_WriteValid), .i_WriteReady(i_WriteReady),
        .o_WriteNumber(o_WriteNumber), .o_WriteValue(o_WriteValue),
        .o_ActiveMask(o_ActiveMask), .o_Busy(o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_mask [32];
    int m_key  [32];
    int m_age  [32];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int first_c, done_c, stalls, phase_writes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = m_mask[i];
        return r;
    endfunction

    function automatic logic [15:0] model_half(input int t);
        logic [31:0] r;
        r = model_mask();
        return (t >= 16) ? r[31:16] : r[15:0];
    endfunction

    function automatic logic [15:0] mask_reg(input int t);
        return (t >= 16) ? 16'h9100 : 16'h9000;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 32; v++) begin
            m_mask[v] = 1'b0;
            m_key[v]  = 0;
            m_age[v]  = v;
        end
    endtask

    // Expected write list and state update for one event, straight from the allocation rules.
    task automatic model_event(input bit on, input int k, input logic [15:0] step);
        int m, f, s, t, old;
        m = -1; f = -1; s = -1;
        for (int v = 0; v < 32; v++) begin
            if (m < 0 && m_mask[v] && m_key[v] == k) m = v;
            if (f < 0 && !m_mask[v]) f = v;
            if (m_age[v] == 31) s = v;
        end
        exp_q.delete();
        if (on) begin
            t = (m >= 0) ? m : (f >= 0) ? f : s;
            if (m >= 0 || f < 0) begin
                m_mask[t] = 1'b0;
                exp_q.push_back({mask_reg(t), model_half(t)});
            end
            for (int op = 0; op < 8; op++)
                exp_q.push_back({16'(32'h8000 + t * 8 + op), step});
            m_mask[t] = 1'b1;
            m_key[t]  = k;
            old = m_age[t];
            for (int v = 0; v < 32; v++) if (m_age[v] < old) m_age[v]++;
            m_age[t] = 0;
            exp_q.push_back({mask_reg(t), model_half(t)});
        end else if (m >= 0) begin
            m_mask[m] = 1'b0;
            exp_q.push_back({mask_reg(m), model_half(m)});
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: stall 5 cycles on write 0x8003.
    task automatic run_event(input bit on, input int k, input logic [15:0] step, input int mode);
        int c, idx;
        bit hold, rdy;
        logic [15:0] prev_num, prev_val;
        check("event_ready_before", {31'd0, o_EventReady}, 32'd1);
        model_event(on, k, step);
        got_q.delete();
        i_EventValid     = 1'b1;
        i_EventNoteOn    = on;
        i_EventKey       = 7'(k);
        i_EventPhaseStep = step;
        @(negedge i_Clock);
        i_EventValid = 1'b0;
        c = 1; idx = 0; first_c = 0; done_c = 0; stalls = 0; phase_writes = 0; hold = 1'b0;
        prev_num = '0; prev_val = '0;
        while (c < 200) begin
            if (o_WriteValid) begin
                if (first_c == 0) first_c = c;
                if (hold) begin
                    check("held_number", {16'd0, o_WriteNumber}, {16'd0, prev_num});
                    check("held_value", {16'd0, o_WriteValue}, {16'd0, prev_val});
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = ($urandom % 3) != 0;
                    default: rdy = !(o_WriteNumber == 16'h8003 && stalls < 5);
                endcase
                if (!rdy && mode == 2) stalls++;
                i_WriteReady = rdy;
                if (rdy) begin
                    got_q.push_back({o_WriteNumber, o_WriteValue});
                    if (o_WriteNumber[13:8] == 6'h00) phase_writes++;
                    if (idx < exp_q.size())
                        check("write", {o_WriteNumber, o_WriteValue}, exp_q[idx]);
                    else
                        check("extra_write", {o_WriteNumber, o_WriteValue}, 32'hxxxxxxxx);
                    idx++;
                end
                hold = !rdy;
                prev_num = o_WriteNumber;
                prev_val = o_WriteValue;
            end else begin
                hold = 1'b0;
                i_WriteReady = (mode == 0) ? 1'b1 : 1'($urandom % 2);
                if (o_EventReady) begin
                    done_c = c;
                    break;
                end
            end
            @(negedge i_Clock);
            c++;
        end
        check("event_done", {31'd0, done_c != 0}, 32'd1);
        check("write_count", idx, exp_q.size());
        check("active_mask", o_ActiveMask, model_mask());
        check("busy_idle", {31'd0, o_Busy}, 32'd0);
    endtask

    initial begin
        bit on;
        int found;
        i_Reset = 1'b1; i_EventValid = 1'b0; i_EventNoteOn = 1'b0; i_EventKey = '0;
        i_EventPhaseStep = '0; i_WriteReady = 1'b1;
        repeat (3) @(negedge i_Clock);
        check("rst_write_valid", {31'd0, o_WriteValid}, 32'd0);
        check("rst_number", {16'd0, o_WriteNumber}, 32'd0);
        check("rst_value", {16'd0, o_WriteValue}, 32'd0);
        check("rst_mask", o_ActiveMask, 32'd0);
        check("rst_busy", {31'd0, o_Busy}, 32'd0);
        check("rst_event_ready", {31'd0, o_EventReady}, 32'd1);
        i_Reset = 1'b0;
        model_reset();

        // Fresh note-on: 8 phase writes then NoteOn set, fixed latency.
        run_event(1'b1, 60, 16'h1234, 0);
        check("t1_first_write_cycle", first_c, 2);
        check("t1_ready_cycle", done_c, 11);
        check("t1_op0", got_q[0], 32'h8000_1234);
        check("t1_op7", got_q[7], 32'h8007_1234);
        check("t1_set", got_q[8], 32'h9000_0001);
        check("t1_mask", o_ActiveMask, 32'h0000_0001);

        // Note-off with and without a matching voice.
        run_event(1'b0, 60, 16'h0, 0);
        check("t2_off_write", got_q[0], 32'h9000_0000);
        check("t2_off_ready_cycle", done_c, 3);
        run_event(1'b0, 61, 16'h0, 0);
        check("t2_nomatch_writes", got_q.size(), 0);
        check("t2_nomatch_ready_cycle", done_c, 2);

        // Fill every voice, then steal the oldest.
        for (int k = 0; k < 32; k++) begin
            run_event(1'b1, k, 16'($urandom), 1);
            if (k == 16) check("t3_voice16_set", got_q[got_q.size() - 1], 32'h9100_0001);
        end
        check("t3_full_mask", o_ActiveMask, 32'hFFFF_FFFF);
        run_event(1'b1, 100, 16'h0BEE, 0);
        check("t3_steal_clear", got_q[0], 32'h9000_FFFE);
        check("t3_steal_op0", got_q[1], 32'h8000_0BEE);
        check("t3_steal_set", got_q[9], 32'h9000_FFFF);
        check("t3_steal_ready_cycle", done_c, 12);
        run_event(1'b0, 0, 16'h0, 0);
        check("t3_stolen_key_off", got_q.size(), 0);

        // Back-pressure in the middle of the phase writes on voice 0.
        run_event(1'b0, 100, 16'h0, 1);
        run_event(1'b1, 70, 16'hA5A5, 2);
        check("t4_stall_cycles", stalls, 5);
        check("t4_phase_writes", phase_writes, 8);
        check("t4_op4_after_op3", got_q[4], 32'h8004_A5A5);

        // Reset while the phase writes are in flight.
        i_EventValid = 1'b1; i_EventNoteOn = 1'b1; i_EventKey = 7'd90; i_EventPhaseStep = 16'h7777;
        @(negedge i_Clock);
        i_EventValid = 1'b0; i_WriteReady = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge i_Clock);
            if (o_WriteValid && o_WriteNumber[13:8] == 6'h00 && o_WriteNumber[2:0] == 3'd2) found = 1;
        end
        check("t6_reached_phase", found, 1);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        check("t6_write_valid", {31'd0, o_WriteValid}, 32'd0);
        check("t6_mask", o_ActiveMask, 32'd0);
        check("t6_event_ready", {31'd0, o_EventReady}, 32'd1);
        i_Reset = 1'b0;
        model_reset();
        run_event(1'b1, 60, 16'h4321, 1);
        check("t6_realloc_voice0", got_q[0], 32'h8000_4321);

        // Retrigger the same key on voice 0.
        run_event(1'b1, 60, 16'h5555, 0);
        check("t5_retrig_clear", got_q[0], 32'h9000_0000);
        check("t5_retrig_op0", got_q[1], 32'h8000_5555);
        check("t5_retrig_set", got_q[9], 32'h9000_0001);
        check("t5_retrig_count", got_q.size(), 10);

        // Random traffic; a small key range forces retriggers, frees and steals.
        for (int n = 0; n < 400; n++) begin
            on = ($urandom % 10) < 7;
            run_event(on, int'($urandom_range(0, 47)), 16'($urandom), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
